pdm_capture_ctrl: RTL

Session controller placed between the PDM capture datapath and the downstream sample consumer (SPI/DMA bridge).
- Accepts start/stop commands.
- Gates the capture datapath via `capture_en`.
- Discards the microphone start-up/filter-settling samples.
- Counts a programmed number of PCM samples.
- Buffers them in an internal FIFO and presents them on a valid/ready stream.
- Reports busy, done and overflow status.

---
 rtl/pdm_pkg.sv | 18 +
 rtl/pdm_sample_fifo.sv | 60 ++++++
 rtl/pdm_capture_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pdm_pkg.sv
// Shared types and default widths for the PDM capture path and its session controller.
// Pure declarations: no latency, no flow control.
package pdm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    CAPTURE,
    DRAIN,
    DONE
  } ctrl_state_t;

  localparam int PCM_WIDTH       = 16;
  localparam int PCM_FIFO_DEPTH  = 256;
  localparam int PCM_WARMUP      = 64;
  localparam int PCM_COUNT_WIDTH = 16;

endpackage

// File: rtl/pdm_sample_fifo.sv
// First-word-fall-through sample FIFO; a write is visible on rd_data/!empty the next cycle.
// Writes into a full FIFO succeed only when a read happens in the same cycle, otherwise they are refused.
module pdm_sample_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           level_q, level_d;
  logic                  wr_ok, rd_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  // A read in the same cycle frees the slot the write needs.
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_ok && !rd_ok)      level_d = level_q + (AW+1)'(1);
    else if (!wr_ok && rd_ok) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// Capture session controller: warm-up discard, sample counting, FWFT output buffer, busy/done/overflow status.
// Output stream is valid/ready with one cycle write-to-valid latency; PDM_CTRL_PEAK_EN adds a peak_abs output.
module pdm_capture_ctrl
  import pdm_pkg::*;
#(
  parameter int DATA_WIDTH     = PCM_WIDTH,
  parameter int FIFO_DEPTH     = PCM_FIFO_DEPTH,
  parameter int WARMUP_SAMPLES = PCM_WARMUP,
  parameter int COUNT_WIDTH    = PCM_COUNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_start,
  input  logic                         cmd_stop,
  input  logic [COUNT_WIDTH-1:0]       sample_target,
  output logic                         capture_en,
  input  logic [DATA_WIDTH-1:0]        pcm_in,
  input  logic                         pcm_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
`ifdef PDM_CTRL_PEAK_EN
  , output logic [DATA_WIDTH-1:0]      peak_abs
`endif
);

  localparam logic [COUNT_WIDTH-1:0] WARM_N = COUNT_WIDTH'(WARMUP_SAMPLES);
  localparam logic [COUNT_WIDTH-1:0] ONE    = COUNT_WIDTH'(1);

  ctrl_state_t             state_q, state_d;
  logic [COUNT_WIDTH-1:0]  target_q, target_d;
  logic [COUNT_WIDTH-1:0]  samp_cnt_q, samp_cnt_d;
  logic [COUNT_WIDTH-1:0]  warm_cnt_q, warm_cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    fifo_full, fifo_empty, fifo_rd, wr_req;
  logic [DATA_WIDTH-1:0]   fifo_rd_data;

  assign wr_req     = (state_q == CAPTURE) && pcm_ready;
  assign fifo_rd    = out_ready && !fifo_empty;
  assign out_valid  = !fifo_empty;
  // Memory is not reset, so keep the bus quiet while nothing is buffered.
  assign out_data   = out_valid ? fifo_rd_data : '0;
  assign busy       = (state_q != IDLE);
  assign overflow   = overflow_q;

  pdm_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_req),
    .wr_data (pcm_in),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    samp_cnt_d = samp_cnt_q;
    warm_cnt_d = warm_cnt_q;
    overflow_d = overflow_q;
    capture_en = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          target_d   = sample_target;
          samp_cnt_d = '0;
          warm_cnt_d = '0;
          overflow_d = 1'b0;
          state_d    = (WARMUP_SAMPLES == 0) ? CAPTURE : WARMUP;
        end
      end
      WARMUP: begin
        capture_en = 1'b1;
        if (pcm_ready) begin
          warm_cnt_d = warm_cnt_q + ONE;
          if (warm_cnt_d == WARM_N) state_d = CAPTURE;
        end
        if (cmd_stop) state_d = DRAIN;
      end
      CAPTURE: begin
        capture_en = 1'b1;
        if (pcm_ready) begin
          // Dropped samples still count toward the target.
          samp_cnt_d = samp_cnt_q + ONE;
          if (fifo_full && !fifo_rd) overflow_d = 1'b1;
          if ((target_q != '0) && (samp_cnt_d == target_q)) state_d = DRAIN;
        end
        if (cmd_stop) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      target_q   <= '0;
      samp_cnt_q <= '0;
      warm_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      samp_cnt_q <= samp_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef PDM_CTRL_PEAK_EN
  localparam logic [DATA_WIDTH-1:0] PCM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] PCM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] peak_q, peak_d, pcm_abs;
  logic                  wr_acc;

  assign wr_acc   = wr_req && (!fifo_full || fifo_rd);
  assign peak_abs = peak_q;

  always_comb begin
    pcm_abs = pcm_in;
    // The most negative code has no positive twin, so it saturates.
    if (pcm_in[DATA_WIDTH-1])
      pcm_abs = (pcm_in == PCM_MIN) ? PCM_MAX : (~pcm_in + DATA_WIDTH'(1));
    peak_d = peak_q;
    if ((state_q == IDLE) && cmd_start) peak_d = '0;
    else if (wr_acc && (pcm_abs > peak_q)) peak_d = pcm_abs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) peak_q <= '0;
    else        peak_q <= peak_d;
  end
`endif

endmodule
